// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: parallel-to-serial feeder for a programmable bit-pattern
// detector. Words are accepted over valid/ready while IDLE. Each word is then
// shifted one bit per clock into a PAT_W-bit history. A registered match pulse
// drives a saturating counter and a sticky threshold interrupt.
//
// Optional build macro SEQ_DET_LSB_EN adds the cfg_lsb_first input, which
// selects LSB-first serialization per word. Without the macro the port is
// absent and words always go out MSB first.
module seq_detect_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              flush,
  input  logic              irq_clr,
`ifdef SEQ_DET_LSB_EN
  input  logic              cfg_lsb_first,
`endif
  output logic              ser_bit,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic              ovl_q,   ovl_d;
  logic [PAT_W-1:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              irq_q,   irq_d;

  logic              accept;
  logic              ser_raw;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit;
  logic              cnt_step;

`ifdef SEQ_DET_LSB_EN
  logic lsb_q, lsb_d;

  // The serial tap follows the bit order captured with the word.
  assign ser_raw = lsb_q ? data_q[0] : data_q[DATA_W-1];
`else
  assign ser_raw = data_q[DATA_W-1];
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign ser_bit   = busy & ser_raw;
  assign accept    = in_valid & in_ready;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;

  // The history and fill level the current serial bit would produce. The fill
  // guard stops the all-zero reset history from matching a zero pattern.
  assign hist_shift = {hist_q[PAT_W-2:0], ser_bit};
  assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign hit        = (hist_shift == pat_q) && (fill_inc == FILL_FULL);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // Compute the next state of the FSM, the serializer and the history.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave a
    // value unassigned and infer a latch.
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
`ifdef SEQ_DET_LSB_EN
    lsb_d   = lsb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = in_data;
          pat_d   = cfg_pattern;
          ovl_d   = cfg_overlap;
          idx_d   = '0;
          state_d = ST_SHIFT;
`ifdef SEQ_DET_LSB_EN
          lsb_d   = cfg_lsb_first;
`endif
        end
        // Flush is independent of accept and takes priority over the history.
        if (flush) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
      ST_SHIFT: begin
`ifdef SEQ_DET_LSB_EN
        data_d = lsb_q ? {1'b0, data_q[DATA_W-1:1]} : {data_q[DATA_W-2:0], 1'b0};
`else
        data_d = {data_q[DATA_W-2:0], 1'b0};
`endif
        hist_d = hist_shift;
        fill_d = fill_inc;
        idx_d  = idx_q + IDX_W'(1);
        if (hit) begin
          match_d = 1'b1;
          // In non-overlap mode the matched bits are not reused.
          if (!ovl_q) begin
            hist_d = '0;
            fill_d = '0;
          end
        end
        if (idx_q == IDX_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Update the saturating counter and the sticky interrupt. A set wins over a
  // simultaneous clear. A saturated counter no longer steps, so it cannot
  // re-trigger the interrupt.
  always_comb begin
    cnt_step = match_d && (cnt_q != CNT_MAX);
    cnt_d    = cnt_step ? cnt_inc : cnt_q;
    irq_d    = irq_clr ? 1'b0 : irq_q;
    if (cnt_step && (cfg_thresh != '0) && (cnt_inc == cfg_thresh)) irq_d = 1'b1;
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge.
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

`ifdef SEQ_DET_LSB_EN
  // Bit-order flag captured with each word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lsb_q <= 1'b0;
    else      lsb_q <= lsb_d;
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl (DATA_W=8, PAT_W=3, CNT_W=8).
// Word vectors come from a table. Each vector lists the expected match bit for
// each of the eight shift edges. Those expectations go into a scoreboard queue
// when the word is driven, and a monitor pops them after every shift edge.
// Hand-written sequences cover the handshake timing, the interrupt, a reset
// in mid-shift and counter saturation.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [2:0] cfg_pattern = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_thresh = '0;
  logic       flush = 1'b0;
  logic       irq_clr = 1'b0;
`ifdef SEQ_DET_LSB_EN
  logic       cfg_lsb_first = 1'b0;
`endif
  logic       ser_bit;
  logic       busy;
  logic       match;
  logic [7:0] match_cnt;
  logic       irq;

  seq_detect_ctrl #(.DATA_W(8), .PAT_W(3), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .flush       (flush),
    .irq_clr     (irq_clr),
`ifdef SEQ_DET_LSB_EN
    .cfg_lsb_first (cfg_lsb_first),
`endif
    .ser_bit     (ser_bit),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    bit         flush_before;
    bit         flush_acc;
    logic [2:0] pat;
    logic       ovl;
    logic [7:0] data;
    logic [7:0] mask;   // bit 7 = match expected after the first shift edge
  } vec_t;

  typedef struct {
    logic       m;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_cnt = 0;
  bit   was_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: after every shift edge, pop one expectation and compare it.
  always @(negedge clk) begin
    if (!rst) begin
      was_busy = 1'b0;
      sb.delete();
    end else begin
      if (was_busy) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL sb_underflow: shift edge with no expectation queued (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("match", match, e.m);
          check("match_cnt", match_cnt, e.cnt);
        end
      end
      was_busy = busy;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((!in_ready || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("idle_timeout", sb.size(), 0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; irq_clr = 1'b0;
    exp_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_match", match, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_irq", irq, 0);
      check("rst_ser_bit", ser_bit, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_match", match, 0);
      check("idle_cnt", match_cnt, 0);
      check("idle_irq", irq, 0);
    end
  endtask

  // Drive one word for the accept edge and queue its expected match bits.
  // Afterwards the config inputs are scrambled: they must be ignored by then.
  task automatic send_word(input logic [2:0] pat, input logic ovl, input logic [7:0] data,
                           input logic [7:0] mask, input bit fl);
    wait_ready();
    cfg_pattern = pat;
    cfg_overlap = ovl;
    in_data     = data;
    in_valid    = 1'b1;
    flush       = fl;
    for (int i = 7; i >= 0; i--) begin
      exp_t e;
      if (mask[i] && exp_cnt != 255) exp_cnt++;
      e.m   = mask[i];
      e.cnt = 8'(exp_cnt);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    flush       = 1'b0;
    cfg_pattern = ~pat;
    cfg_overlap = ~ovl;
    in_data     = ~data;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          rst   flb   fla   pat     ovl   data   mask
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 8'h54, 8'b0001_0100};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 8'h54, 8'b0001_0000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 8'h02, 8'b0000_0000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 3'b101, 1'b1, 8'h80, 8'b1000_0000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b101, 1'b1, 8'h02, 8'b0000_0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'b101, 1'b1, 8'h80, 8'b0000_0000};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 8'h00, 8'b0011_1111};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 8'b1001_0010};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 8'hD6, 8'b0010_0001};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 3'b101, 1'b1, 8'h80, 8'b0000_0000};

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst_before) begin
        wait_idle();
        reset_dut();
      end
      if (vecs[v].flush_before) begin
        wait_ready();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
      send_word(vecs[v].pat, vecs[v].ovl, vecs[v].data, vecs[v].mask, vecs[v].flush_acc);
    end
    wait_idle();

    // Handshake timing and the interrupt at threshold 2.
    reset_dut();
    cfg_thresh = 8'd2;
    send_word(3'b101, 1'b1, 8'h54, 8'b0001_0100, 1'b0);
    @(negedge clk);
    check("e0_busy", busy, 1);
    check("e0_in_ready", in_ready, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) check("irq_after_first", irq, 0);
      if (k == 6) check("irq_after_second", irq, 1);
      if (k == 7) check("busy_mid", busy, 1);
      if (k == 8) begin
        check("e8_busy", busy, 0);
        check("e8_in_ready", in_ready, 1);
      end
    end
    wait_idle();

    // A set coinciding with irq_clr must win; the clear acts one edge later.
    reset_dut();
    cfg_thresh = 8'd2;
    irq_clr = 1'b1;
    send_word(3'b101, 1'b1, 8'h54, 8'b0001_0100, 1'b0);
    irq_clr = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 4) check("irqclr_e4", irq, 0);
      if (k == 6) check("irqclr_set_wins", irq, 1);
      if (k == 7) check("irqclr_clears", irq, 0);
    end
    irq_clr = 1'b0;
    cfg_thresh = 8'd0;
    wait_idle();

    // Reset during the fourth SHIFT cycle discards the word.
    reset_dut();
    send_word(3'b101, 1'b1, 8'h54, 8'b0001_0100, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_match", match, 0);
    check("midrst_cnt", match_cnt, 0);
    check("midrst_irq", irq, 0);
    check("midrst_ser_bit", ser_bit, 0);
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("postrst_match", match, 0);
      check("postrst_busy", busy, 0);
      check("postrst_cnt", match_cnt, 0);
    end

    // Saturation: the counter reaching 255 sets irq once; later matches cannot re-set it.
    reset_dut();
    cfg_thresh = 8'd255;
    send_word(3'b000, 1'b1, 8'h00, 8'b0011_1111, 1'b0);
    for (int w = 0; w < 32; w++) send_word(3'b000, 1'b1, 8'h00, 8'hFF, 1'b0);
    wait_idle();
    check("sat_cnt", match_cnt, 255);
    check("sat_irq", irq, 1);
    irq_clr = 1'b1;
    @(posedge clk);
    #1 irq_clr = 1'b0;
    @(negedge clk);
    check("sat_irq_cleared", irq, 0);
    send_word(3'b000, 1'b1, 8'h00, 8'hFF, 1'b0);
    wait_idle();
    check("sat_no_retrigger", irq, 0);
    check("sat_cnt_hold", match_cnt, 255);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
